// File: rtl/md_unit_pkg.sv
// Shared XALU opcode constants, FSM state type and opcode classification helpers
// used by the multiply/divide unit and its datapath.
package md_unit_pkg;

  typedef enum logic [3:0] {
    XALU_NONE  = 4'd0,
    XALU_MULT  = 4'd1,
    XALU_MULTU = 4'd2,
    XALU_DIV   = 4'd3,
    XALU_DIVU  = 4'd4,
    XALU_MTHI  = 4'd5,
    XALU_MTLO  = 4'd6,
    XALU_MADD  = 4'd7,
    XALU_MADDU = 4'd8,
    XALU_MSUB  = 4'd9,
    XALU_MSUBU = 4'd10
  } xalu_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } md_state_e;

  localparam int CNT_W = 4;

  function automatic logic is_div(input logic [3:0] op);
    return (op == XALU_DIV) || (op == XALU_DIVU);
  endfunction

  function automatic logic is_multicycle(input logic [3:0] op);
    logic res;
    case (op)
      XALU_MULT, XALU_MULTU, XALU_DIV, XALU_DIVU,
      XALU_MADD, XALU_MADDU, XALU_MSUB, XALU_MSUBU: res = 1'b1;
      default:                                      res = 1'b0;
    endcase
    return res;
  endfunction

  // Opcodes 11-15 decode as "none" and are never accepted.
  function automatic logic is_valid(input logic [3:0] op);
    return (op != XALU_NONE) && (op <= XALU_MSUBU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational HI/LO datapath: 64-bit multiply/accumulate, signed/unsigned
// divide and mthi/mtlo, producing the next {hi, lo} from the current values.
module md_calc
  import md_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] hi_next,
  output logic [31:0] lo_next
);

  logic [63:0] acc;
  logic [63:0] sprod;
  logic [63:0] uprod;
  logic [63:0] res;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    acc   = {hi, lo};
    // Low 64 bits of the product of sign-extended operands equal the signed product.
    sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    uprod = {32'd0, a} * {32'd0, b};
    a_mag = a[31] ? -a : a;
    b_mag = b[31] ? -b : b;
    q_mag = '0;
    r_mag = '0;
    // Magnitude divide then re-sign: 0x80000000 / -1 falls out as LO=0x80000000, HI=0.
    if (b != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    res = acc;
    case (op)
      XALU_MULT:  res = sprod;
      XALU_MULTU: res = uprod;
      XALU_MADD:  res = acc + sprod;
      XALU_MADDU: res = acc + uprod;
      XALU_MSUB:  res = acc - sprod;
      XALU_MSUBU: res = acc - uprod;
      XALU_DIV: begin
        if (b != '0) begin
          res = {(a[31] ? -r_mag : r_mag), ((a[31] ^ b[31]) ? -q_mag : q_mag)};
        end
      end
      XALU_DIVU: begin
        if (b != '0) begin
          res = {a % b, a / b};
        end
      end
      XALU_MTHI:  res = {a, lo};
      XALU_MTLO:  res = {hi, a};
      default:    res = acc;
    endcase
    hi_next = res[63:32];
    lo_next = res[31:0];
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, computes the result at acceptance,
// holds it in pending registers for N busy cycles, then commits.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        int_req,
  output logic        busy,
  output logic        stall_x,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      calc_hi;
  logic [31:0]      calc_lo;
  logic             accept;

  md_calc u_calc (
    .op      (op),
    .a       (a),
    .b       (b),
    .hi      (hi_q),
    .lo      (lo_q),
    .hi_next (calc_hi),
    .lo_next (calc_lo)
  );

  assign busy    = (state_q == ST_RUN);
  assign stall_x = start & is_multicycle(op) & ~int_req;
  assign accept  = start & ~int_req & ~busy & is_valid(op);
  assign hi      = hi_q;
  assign lo      = lo_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_multicycle(op)) begin
            state_d   = ST_RUN;
            cnt_d     = is_div(op) ? DIV_LOAD : MULT_LOAD;
            pend_hi_d = calc_hi;
            pend_lo_d = calc_lo;
          end else begin
            hi_d = calc_hi;
            lo_d = calc_lo;
          end
        end
      end
      ST_RUN: begin
        // int_req is deliberately ignored here: the owning instruction has left E.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: directed ops push hand-computed {hi,lo} and busy
// length; a monitor pops and compares on every busy falling edge.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        int_req;
  logic        busy;
  logic        stall_x;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .int_req (int_req),
    .busy    (busy),
    .stall_x (stall_x),
    .hi      (hi),
    .lo      (lo)
  );

  typedef struct {
    string       name;
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mon_busy_prev = 1'b0;
  int   mon_busy_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a busy falling edge outside reset is a commit.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_busy_prev = 1'b0;
        mon_busy_cnt  = 0;
      end else begin
        if (busy) begin
          mon_busy_cnt++;
        end else if (mon_busy_prev) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_commit: got hilo 0x%0h, expected no commit", {hi, lo});
          end else begin
            e = sb.pop_front();
            check({e.name, "_hilo"}, {hi, lo}, e.res);
            check({e.name, "_busy_cycles"}, 64'(mon_busy_cnt), 64'(e.cyc));
          end
          mon_busy_cnt = 0;
        end
        mon_busy_prev = busy;
      end
    end
  end

  // Called at a falling edge; drives one start cycle and returns at the next falling edge.
  task automatic issue(input string name, input logic [3:0] o, input logic [31:0] ai,
                       input logic [31:0] bi, input logic ir, input logic [63:0] exp_res,
                       input bit expect_commit);
    bit   mc;
    exp_t e;
    mc = o inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10};
    start   = 1'b1;
    op      = o;
    a       = ai;
    b       = bi;
    int_req = ir;
    #1;
    check({name, "_stall_x"}, 64'(stall_x), 64'(mc & ~ir));
    if (expect_commit && mc) begin
      e.name = name;
      e.res  = exp_res;
      e.cyc  = (o == 4'd3 || o == 4'd4) ? DC : MC;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    int_req = 1'b0;
    op      = 4'd0;
    if (expect_commit && !mc) check({name, "_hilo"}, {hi, lo}, exp_res);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin : stimulus
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 4'd0;
    a       = '0;
    b       = '0;
    int_req = 1'b0;
    #2;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    issue("mult",  XALU_MULT,  32'hFFFFFFFF, 32'd2, 1'b0, 64'hFFFFFFFF_FFFFFFFE, 1'b1); wait_idle();
    issue("multu", XALU_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 64'h00000001_FFFFFFFE, 1'b1); wait_idle();
    issue("div",   XALU_DIV,   32'hFFFFFFF9, 32'd2, 1'b0, 64'hFFFFFFFF_FFFFFFFD, 1'b1); wait_idle();
    issue("divu",  XALU_DIVU,  32'd7,        32'd2, 1'b0, 64'h00000001_00000003, 1'b1); wait_idle();
    issue("div0",  XALU_DIVU,  32'd5,        32'd0, 1'b0, 64'h00000001_00000003, 1'b1); wait_idle();
    issue("div_ovf", XALU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h00000000_80000000, 1'b1); wait_idle();
    issue("mthi",  XALU_MTHI,  32'd0,  32'd0, 1'b0, 64'h00000000_80000000, 1'b1);
    issue("mtlo",  XALU_MTLO,  32'd10, 32'd0, 1'b0, 64'h00000000_0000000A, 1'b1);
    issue("madd",  XALU_MADD,  32'd3,  32'd4, 1'b0, 64'h00000000_00000016, 1'b1); wait_idle();
    issue("msubu", XALU_MSUBU, 32'd5,  32'd5, 1'b0, 64'hFFFFFFFF_FFFFFFFD, 1'b1); wait_idle();
    issue("maddu", XALU_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFD_FFFFFFFE, 1'b1); wait_idle();
    issue("msub",  XALU_MSUB,  32'hFFFFFFFF, 32'd3, 1'b0, 64'hFFFFFFFE_00000001, 1'b1); wait_idle();
    issue("madd_neg", XALU_MADD, 32'hFFFFFFFE, 32'd3, 1'b0, 64'hFFFFFFFD_FFFFFFFB, 1'b1); wait_idle();

    // Flushed start and an out-of-range opcode leave everything untouched.
    issue("flush", XALU_MULT, 32'd7, 32'd7, 1'b1, 64'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hilo", {hi, lo}, 64'hFFFFFFFD_FFFFFFFB);
    issue("op11", 4'd11, 32'd1, 32'd2, 1'b0, 64'd0, 1'b0);
    check("op11_busy", 64'(busy), 64'd0);
    check("op11_hilo", {hi, lo}, 64'hFFFFFFFD_FFFFFFFB);

    // Starts while busy are ignored; the original result commits on schedule.
    issue("busy_mult", XALU_MULT, 32'd3, 32'd5, 1'b0, 64'h00000000_0000000F, 1'b1);
    start = 1'b1; op = XALU_MTLO; a = 32'hDEAD;
    @(negedge clk);
    op = XALU_DIV; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    wait_idle();
    @(negedge clk);
    check("busy_ignored_hilo", {hi, lo}, 64'h00000000_0000000F);

    // Interrupt during RUN does not cancel the op.
    issue("int_divu", XALU_DIVU, 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 1'b1);
    int_req = 1'b1;
    repeat (3) @(negedge clk);
    int_req = 1'b0;
    wait_idle();

    // Reset mid-divide aborts it and no commit follows.
    issue("rst_div", XALU_DIV, 32'd100, 32'd7, 1'b0, 64'd0, 1'b0);
    repeat (3) @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    #3 reset_n = 1'b1;
    repeat (15) @(negedge clk);
    check("postrst_busy", 64'(busy), 64'd0);
    check("postrst_hilo", {hi, lo}, 64'd0);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit (XALU) in the E stage of the pipelined MIPS core. It owns the HI/LO registers, executes mult/multu/div/divu/madd/maddu/msub/msubu/mthi/mtlo, and drives the `busy`/`stall_x` signals that the D-stage hazard unit uses to stall instructions needing HI/LO. It also accepts the interrupt request so that a start in a flushed E slot never commits.

## Interface
- `MULT_CYC`, default 5: busy cycles for mult/multu/madd/maddu/msub/msubu.
- `DIV_CYC`, default 10: busy cycles for div/divu.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: E-stage instruction is an XALU op this cycle.
- `op` in 4: XALU opcode. Values: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu. Values 11–15 are treated as none.
- `a` in 32: forwarded rs value.
- `b` in 32: forwarded rt value.
- `int_req` in 1: interrupt/exception flush of E this cycle.
- `busy` out 1: a multi-cycle op is in flight (registered).
- `stall_x` out 1: combinational; `start & multicycle(op) & ~int_req`.
- `hi` out 32: architectural HI.
- `lo` out 32: architectural LO.

## Operation
- **Reset:** `busy`=0, `hi`=0, `lo`=0, counter=0, pending result=0. Reset asserted mid-operation aborts it and HI/LO stay 0.
- **Accept:** `start & ~int_req & ~busy` with `op`≠none.
- **Ignored start:** with `int_req`=1, or with `busy`=1 (protocol violation), `start` is ignored and no state changes.
- **mthi/mtlo:** `hi`←`a` or `lo`←`a` at the accepting edge. No busy.
- **mult:** signed 64-bit `a*b` → {HI,LO}.
- **multu:** unsigned 64-bit `a*b` → {HI,LO}.
- **madd/maddu:** {HI,LO} + product (signed/unsigned product), mod 2^64.
- **msub/msubu:** {HI,LO} − product, mod 2^64.
- **div:** LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
- **divu:** unsigned quotient and remainder.
- **Divide by zero:** full `DIV_CYC` busy; HI/LO unchanged at completion.
- **Overflow case** (0x80000000 / −1, signed): LO=0x80000000, HI=0.
- **Compute and hold:** the result is computed from `a`, `b` and the current {HI,LO} at the accepting edge and held in pending registers. madd/msub accumulate against HI/LO as of acceptance.
- **States:** IDLE → RUN (counter loaded with N−1) → IDLE.
  - RUN decrements the counter each cycle.
  - When counter=0 in RUN, the next edge commits the pending result to HI/LO, clears `busy`, and returns to IDLE.
- **Interrupts:** an in-flight op always completes. `int_req` during RUN has no effect, because the instruction is past E.

## Timing
- Accept at edge k: `busy`=1 in cycles k+1 … k+N, where N is `MULT_CYC` or `DIV_CYC`.
- New HI/LO are visible from cycle k+N+1, the same edge at which `busy` falls.
- Back-to-back: `start` is legal in cycle k+N+1; it sees the committed HI/LO.
- `stall_x` is high only in the accepting cycle. `busy` covers the following cycles, so the hazard unit stalls on `stall_x | busy`.
- mthi/mtlo: `hi`/`lo` are updated at the edge ending the start cycle, with 1-cycle latency.
- Counter width is 4 bits, so `MULT_CYC` and `DIV_CYC` must each be ≤16.

## Structure
- Opcode constants (`XALU_*`) live in the shared macro/constant include alongside the other decode constants.
- One sub-module, `md_calc`: combinational 64-bit multiply/accumulate and divide producing {hi_next, lo_next} from op, a, b, hi, lo.
- The top level holds the FSM, the counter, the pending registers and HI/LO.

## Test plan
- **Signed mult:** mult a=0xFFFFFFFF, b=2 → `busy` high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE; `stall_x`=1 only in the start cycle.
- **Unsigned mult:** multu, same operands → hi=0x00000001, lo=0xFFFFFFFE.
- **Signed div:** div a=−7 (0xFFFFFFF9), b=2 → `busy` 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- **Unsigned div:** divu 7/2 → lo=3, hi=1.
- **Divide by zero:** hi/lo unchanged after 10 cycles.
- **Accumulate:** mthi 0, mtlo 10, then madd 3×4 → lo=22. Then msubu 5×5 → {hi,lo}=0xFFFFFFFF_FFFFFFFD.
- **Flushed start:** start mult with int_req=1 → `busy` stays 0, hi/lo unchanged, `stall_x`=0.
- **Start while busy:** start during busy → ignored; original result commits on schedule.
- **Mid-op interrupt:** int_req during RUN → op still commits on schedule.
- **Mid-op reset:** reset_n low mid-divide → `busy`=0, hi=lo=0 immediately, no later commit.
